dspl_mux_drv: RTL and testbench

Parametrised multiplexed seven-segment display driver, the successor to the fixed 8-digit Nexys A7 driver. It scans `N_DIGITS` common-anode digits with a configurable slot rate and adds four features:
- an anti-ghosting blank interval at the start of each slot,
- 16-level global brightness by PWM inside each slot,
- a per-digit blink mask,
- a frame-complete strobe.

It sits between the system's display-formatting logic and the board's anode/cathode pins.

---
 rtl/dspl_mux_drv.sv | 209 ++++++++++++++++++++
 tb/tb_dspl_mux_drv.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dspl_mux_drv.sv
`default_nettype none
// ============================================================================
// Module   : dspl_mux_drv
// Purpose  : Multiplexed common-anode seven-segment display driver with
//            anti-ghosting blank interval, 16-level PWM brightness,
//            per-digit blink mask and a frame-complete strobe.
// Revision : 1.0 - initial release
// ============================================================================
module dspl_mux_drv #(
    parameter int N_DIGITS  = 8,
    parameter int CLK_HZ    = 100_000_000,
    parameter int SLOT_HZ   = 1000,
    parameter int BLANK_CYC = 100,
    parameter int BLINK_MS  = 500
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   blink,
    input  logic [3:0]            bright,
    output logic [7:0]            dec_cat,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_SLOT_CYC    = CLK_HZ / SLOT_HZ;
    localparam int c_BLINK_TICKS = SLOT_HZ * BLINK_MS / 1000;

    localparam int c_CNT_W = (c_SLOT_CYC > 1)    ? $clog2(c_SLOT_CYC)    : 1;
    localparam int c_SEL_W = (N_DIGITS > 1)      ? $clog2(N_DIGITS)      : 1;
    localparam int c_BLK_W = (c_BLINK_TICKS > 1) ? $clog2(c_BLINK_TICKS) : 1;
    // Wide enough for SLOT_CYC*16 so the on-time product never overflows.
    localparam int c_ON_W  = $clog2(c_SLOT_CYC * 16 + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_SLOT_CYC - 1);
    localparam logic [c_SEL_W-1:0] c_SEL_LAST = c_SEL_W'(N_DIGITS - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(c_BLINK_TICKS - 1);
    localparam logic [c_ON_W-1:0]  c_LIT_SPAN = c_ON_W'(c_SLOT_CYC - BLANK_CYC);
    localparam logic [c_ON_W-1:0]  c_BLANK    = c_ON_W'(BLANK_CYC);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_SEL_W-1:0]  r_sel;
    logic [c_BLK_W-1:0]  r_blink_cnt;
    logic                r_blink_phase;
    logic [5:0]          r_sh_digit;
    logic [3:0]          r_sh_bright;
    logic [N_DIGITS-1:0] r_an;
    logic [7:0]          r_dec_cat;
    logic                r_frame_tick;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic                w_slot_tick;
    logic                w_slot_start;
    logic [5:0]          w_live_digit;
    logic                w_blink_sel;
    logic [5:0]          w_field;
    logic [3:0]          w_bright;
    logic [c_ON_W-1:0]   w_prod;
    logic [c_ON_W-1:0]   w_on;
    logic [c_ON_W-1:0]   w_cnt_ext;
    logic                w_lit;
    logic [6:0]          w_glyph;
    logic [N_DIGITS-1:0] w_an_next;
    logic [7:0]          w_cat_next;

    assign w_slot_tick  = (r_cnt == c_CNT_LAST);
    assign w_slot_start = (r_cnt == '0);

    // Slot-cycle counter; its wrap is the slot tick.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_slot_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Digit select advances once per slot and wraps after the last digit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sel <= '0;
        end else if (w_slot_tick) begin
            if (r_sel == c_SEL_LAST) begin
                r_sel <= '0;
            end else begin
                r_sel <= r_sel + c_SEL_W'(1);
            end
        end
    end

    // Blink phase toggles every BLINK_TICKS slot ticks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_slot_tick) begin
            if (r_blink_cnt == c_BLK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_BLK_W'(1);
            end
        end
    end

    // Pick the live digit field and blink bit for the selected digit; a
    // constant-index scan avoids variable-width part selects.
    always_comb begin
        w_live_digit = '0;
        w_blink_sel  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_sel == c_SEL_W'(i)) begin
                w_live_digit = digits[6*i +: 6];
                w_blink_sel  = blink[i];
            end
        end
    end

    // Capture digit field and brightness on the first cycle of each slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sh_digit  <= '0;
            r_sh_bright <= '0;
        end else if (w_slot_start) begin
            r_sh_digit  <= w_live_digit;
            r_sh_bright <= bright;
        end
    end

    // On the capture cycle itself the shadow is not loaded yet, so the live
    // values are used; from then on the frozen shadow copy drives the slot.
    assign w_field  = w_slot_start ? w_live_digit : r_sh_digit;
    assign w_bright = w_slot_start ? bright       : r_sh_bright;

    // PWM on-time and lit-window decision for the current cycle.
    always_comb begin
        w_prod    = c_LIT_SPAN * (c_ON_W'(w_bright) + c_ON_W'(1));
        w_on      = w_prod >> 4;
        w_cnt_ext = c_ON_W'(r_cnt);
        w_lit     = (w_cnt_ext >= c_BLANK) &&
                    (w_cnt_ext < (c_BLANK + w_on)) &&
                    w_field[5] &&
                    !(w_blink_sel && r_blink_phase);
    end

    // Only the selected anode may go low, and only inside its lit window.
    always_comb begin
        w_an_next = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if ((r_sel == c_SEL_W'(i)) && w_lit) begin
                w_an_next[i] = 1'b0;
            end
        end
    end

    // Hex-to-glyph decode, segments {a,b,c,d,e,f,g} active-low.
    always_comb begin
        w_glyph = 7'b1111111;
        unique case (w_field[4:1])
            4'h0: w_glyph = 7'b0000001;
            4'h1: w_glyph = 7'b1001111;
            4'h2: w_glyph = 7'b0010010;
            4'h3: w_glyph = 7'b0000110;
            4'h4: w_glyph = 7'b1001100;
            4'h5: w_glyph = 7'b0100100;
            4'h6: w_glyph = 7'b0100000;
            4'h7: w_glyph = 7'b0001111;
            4'h8: w_glyph = 7'b0000000;
            4'h9: w_glyph = 7'b0000100;
            4'hA: w_glyph = 7'b0001000;
            4'hB: w_glyph = 7'b1100000;
            4'hC: w_glyph = 7'b0110001;
            4'hD: w_glyph = 7'b1000010;
            4'hE: w_glyph = 7'b0110000;
            4'hF: w_glyph = 7'b0111000;
            default: w_glyph = 7'b1111111;
        endcase
        w_cat_next = {w_glyph, ~w_field[0]};
    end

    // Output registers: one clock behind the internal slot state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_an         <= '1;
            r_dec_cat    <= 8'hFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an_next;
            r_dec_cat    <= w_cat_next;
            r_frame_tick <= w_slot_start && (r_sel == '0);
        end
    end

    assign an         = r_an;
    assign dec_cat    = r_dec_cat;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_dspl_mux_drv.sv
`default_nettype none
// ============================================================================
// Module   : tb_dspl_mux_drv
// Purpose  : Directed self-checking bench for dspl_mux_drv
//            (4 digits, 10-cycle slots, 2 blank cycles, 3-tick blink).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dspl_mux_drv;

    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] digits;
    logic [3:0]  blink;
    logic [3:0]  bright;
    logic [7:0]  dec_cat;
    logic [3:0]  an;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int oc;      // output-cycle index since the last reset release

    always #5 clock = ~clock;

    dspl_mux_drv #(
        .N_DIGITS  (4),
        .CLK_HZ    (1000),
        .SLOT_HZ   (100),
        .BLANK_CYC (2),
        .BLINK_MS  (30)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .digits     (digits),
        .blink      (blink),
        .bright     (bright),
        .dec_cat    (dec_cat),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s oc=%0d: observed=%b expected=%b", tag, oc, obs, exp);
        end
    endtask

    // Advance on falling edges until output cycle 'target' is on the pins.
    task automatic goto_oc(input int target);
        while (oc < target) begin
            @(negedge clock);
            oc++;
        end
    endtask

    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] exp_cat [4] = '{8'h02, 8'h9F, 8'h11, 8'h71};

    initial begin
        // digit3 = F, digit2 = A, digit1 = 1, digit0 = 0 with dp; all enabled
        reset  = 1'b0;
        digits = {6'h3E, 6'h34, 6'h22, 6'h21};
        blink  = 4'b0000;
        bright = 4'd15;
        oc     = -1;

        repeat (3) @(negedge clock);
        chk("rst_an",    {4'h0, an}, 8'h0F);
        chk("rst_cat",   dec_cat, 8'hFF);
        chk("rst_frame", {7'h0, frame_tick}, 8'h00);

        reset = 1'b1;

        // First frame: every cycle of every slot
        for (int s = 0; s < 4; s++) begin
            for (int idx = 0; idx < 10; idx++) begin
                goto_oc(s * 10 + idx);
                chk("scan_an", {4'h0, an}, {4'h0, (idx >= 2) ? exp_an[s] : 4'hF});
                if (idx == 0) begin
                    chk("scan_frame", {7'h0, frame_tick}, (s == 0) ? 8'h01 : 8'h00);
                end
                if (idx == 0 || idx == 7) begin
                    chk("scan_cat", dec_cat, exp_cat[s]);
                end
            end
        end

        // Second frame starts 40 cycles later; bright change mid-slot 4
        goto_oc(40);
        chk("frame_rep", {7'h0, frame_tick}, 8'h01);
        bright = 4'd7;
        goto_oc(41);
        chk("frame_one", {7'h0, frame_tick}, 8'h00);
        goto_oc(45);
        chk("br_mid_45", {4'h0, an}, 8'h0E);
        goto_oc(49);
        chk("br_mid_49", {4'h0, an}, 8'h0E);

        // Slot 5 (digit 1) at brightness 7: lit indices 2..5
        goto_oc(50);
        chk("frame_s5", {7'h0, frame_tick}, 8'h00);
        goto_oc(52);
        chk("br7_52", {4'h0, an}, 8'h0D);
        goto_oc(55);
        chk("br7_55", {4'h0, an}, 8'h0D);
        goto_oc(56);
        chk("br7_56", {4'h0, an}, 8'h0F);
        bright = 4'd0;

        // Slot 6 (digit 2) at brightness 0: dark throughout
        goto_oc(62);
        chk("br0_62", {4'h0, an}, 8'h0F);
        goto_oc(65);
        chk("br0_65", {4'h0, an}, 8'h0F);
        goto_oc(69);
        chk("br0_69", {4'h0, an}, 8'h0F);

        // Restore brightness mid-slot 7 and disable digit 2
        goto_oc(70);
        bright     = 4'd15;
        digits[17] = 1'b0;
        goto_oc(72);
        chk("br0_72", {4'h0, an}, 8'h0F);
        goto_oc(82);
        chk("br15_82", {4'h0, an}, 8'h0E);

        // Slot 10 (digit 2) disabled: dark, cathodes still driven
        goto_oc(102);
        chk("en0_an", {4'h0, an}, 8'h0F);
        chk("en0_cat", dec_cat, 8'h11);
        goto_oc(105);
        chk("en0_105", {4'h0, an}, 8'h0F);
        goto_oc(110);
        digits[17] = 1'b1;

        // Blink on digit 0: phase is 0 in slots 12..14, 1 in 15..17, ...
        goto_oc(122);
        chk("bl_s12", {4'h0, an}, 8'h0E);
        goto_oc(163);
        chk("bl_pre", {4'h0, an}, 8'h0E);
        blink = 4'b0001;
        goto_oc(164);
        chk("bl_next", {4'h0, an}, 8'h0F);
        goto_oc(172);
        chk("bl_other", {4'h0, an}, 8'h0D);
        goto_oc(202);
        chk("bl_s20", {4'h0, an}, 8'h0E);
        goto_oc(242);
        chk("bl_s24", {4'h0, an}, 8'h0E);
        goto_oc(280);
        chk("frame_s28", {7'h0, frame_tick}, 8'h01);
        goto_oc(282);
        chk("bl_s28", {4'h0, an}, 8'h0F);

        // Reset at index 5 of slot 30 (digit 2, re-enabled)
        goto_oc(305);
        chk("pre_rst", {4'h0, an}, 8'h0B);
        reset = 1'b0;
        #1;
        chk("mid_rst_an",    {4'h0, an}, 8'h0F);
        chk("mid_rst_cat",   dec_cat, 8'hFF);
        chk("mid_rst_frame", {7'h0, frame_tick}, 8'h00);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        oc    = -1;
        goto_oc(0);
        chk("rel_frame", {7'h0, frame_tick}, 8'h01);
        chk("rel_an",    {4'h0, an}, 8'h0F);
        chk("rel_cat",   dec_cat, 8'h02);
        goto_oc(1);
        chk("rel_frame1", {7'h0, frame_tick}, 8'h00);
        goto_oc(2);
        chk("rel_an2", {4'h0, an}, 8'h0E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
